// File: rtl/ha_response_checker_pkg.sv
// Shared types and constants for the half-adder response checker.
// Also holds the golden half-adder function the compare logic uses.
package ha_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ha_chk_state_t;

  localparam logic [15:0] DEF_MISR_POLY = 16'h1021;
  localparam logic [15:0] DEF_MISR_SEED = 16'hFFFF;

  // Golden response packed as {carry, sum}.
  function automatic logic [1:0] ha_expected(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/ha_response_checker_if.sv
// Stimulus/response bus plus result outputs of the checker.
// master = the side that feeds samples in, slave = the checker.
interface ha_response_checker_if #(
  parameter int CNT_W  = 8,
  parameter int MISR_W = 16
);
  logic              start;
  logic              in_valid;
  logic              a;
  logic              b;
  logic              sum;
  logic              carry;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  err_count;
  logic [CNT_W-1:0]  first_err_idx;
  logic [MISR_W-1:0] signature;

  modport master (
    output start, in_valid, a, b, sum, carry,
    input  busy, done, pass, err_count, first_err_idx, signature
  );

  modport slave (
    input  start, in_valid, a, b, sum, carry,
    output busy, done, pass, err_count, first_err_idx, signature
  );
endinterface

// File: rtl/ha_response_checker_misr.sv
// Multiple-input signature register: Galois shift with a 2-bit input
// folded into the low bits each enabled cycle.
module misr #(
  parameter int               W    = 16,
  parameter logic [W-1:0]     POLY = W'(16'h1021),
  parameter logic [W-1:0]     SEED = W'(16'hFFFF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [1:0]   din,
  output logic [W-1:0] sig
);

  logic [W-1:0] sig_nxt;

  always_comb begin
    sig_nxt = {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ {{(W-2){1'b0}}, din};
  end

  always_ff @(posedge clk) begin
    if (rst || load) sig <= SEED;
    else if (en)     sig <= sig_nxt;
  end

endmodule

// File: rtl/ha_response_checker.sv
// Checks half-adder responses against the golden function, counts and
// locates mismatches, and compacts received responses into a MISR signature.
module ha_response_checker
  import ha_check_pkg::*;
#(
  parameter int                NUM_VECTORS = 100,
  parameter int                CNT_W       = 8,
  parameter int                MISR_W      = 16,
  parameter logic [MISR_W-1:0] MISR_POLY   = MISR_W'(DEF_MISR_POLY),
  parameter logic [MISR_W-1:0] MISR_SEED   = MISR_W'(DEF_MISR_SEED)
) (
  input  logic                  clk,
  input  logic                  rst,
  ha_response_checker_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  ha_chk_state_t    state_q, state_d;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] first_q;
  logic             err_seen_q;

  logic       accept;
  logic       init;
  logic       last;
  logic [1:0] exp_cs;
  logic       mismatch;

  // start only initialises a run from IDLE/DONE; a coincident sample is dropped
  assign accept   = (state_q == RUN) && bus.in_valid;
  assign init     = (state_q != RUN) && bus.start;
  assign last     = accept && (idx_q == LAST_IDX);
  assign exp_cs   = ha_expected(bus.a, bus.b);
  assign mismatch = exp_cs != {bus.carry, bus.sum};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (bus.start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || init) begin
      idx_q      <= '0;
      err_q      <= '0;
      first_q    <= '1;
      err_seen_q <= 1'b0;
    end else if (accept) begin
      idx_q <= idx_q + CNT_W'(1);
      if (mismatch) begin
        if (err_q != '1) err_q <= err_q + CNT_W'(1);
        if (!err_seen_q) begin
          first_q    <= idx_q;
          err_seen_q <= 1'b1;
        end
      end
    end
  end

  misr #(
    .W    (MISR_W),
    .POLY (MISR_POLY),
    .SEED (MISR_SEED)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (init),
    .en   (accept),
    .din  ({bus.carry, bus.sum}),
    .sig  (bus.signature)
  );

  assign bus.busy          = (state_q == RUN);
  assign bus.done          = (state_q == DONE);
  assign bus.pass          = (state_q == DONE) && (err_q == '0);
  assign bus.err_count     = err_q;
  assign bus.first_err_idx = first_q;

endmodule

// File: tb/tb_ha_response_checker.sv
// Directed bench: four checker instances cover the 100-vector, single-vector
// and narrow-counter configurations with hand-computed expectations.
module tb_ha_response_checker;
  import ha_check_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  ha_response_checker_if #(.CNT_W(8), .MISR_W(16)) b100 ();
  ha_response_checker_if #(.CNT_W(8), .MISR_W(16)) b1   ();
  ha_response_checker_if #(.CNT_W(2), .MISR_W(16)) b3   ();
  ha_response_checker_if #(.CNT_W(2), .MISR_W(16)) b4   ();

  ha_response_checker #(.NUM_VECTORS(100), .CNT_W(8)) u100 (.clk(clk), .rst(rst), .bus(b100.slave));
  ha_response_checker #(.NUM_VECTORS(1),   .CNT_W(8)) u1   (.clk(clk), .rst(rst), .bus(b1.slave));
  ha_response_checker #(.NUM_VECTORS(3),   .CNT_W(2)) u3   (.clk(clk), .rst(rst), .bus(b3.slave));
  ha_response_checker #(.NUM_VECTORS(4),   .CNT_W(2)) u4   (.clk(clk), .rst(rst), .bus(b4.slave));

  // Waits for a falling edge, then drives one instance and idles the rest.
  task automatic cyc(input int which, input bit st, input bit v,
                     input bit a, input bit b, input bit s, input bit c);
    @(negedge clk);
    {b100.start, b100.in_valid, b100.a, b100.b, b100.sum, b100.carry} = '0;
    {b1.start,   b1.in_valid,   b1.a,   b1.b,   b1.sum,   b1.carry}   = '0;
    {b3.start,   b3.in_valid,   b3.a,   b3.b,   b3.sum,   b3.carry}   = '0;
    {b4.start,   b4.in_valid,   b4.a,   b4.b,   b4.sum,   b4.carry}   = '0;
    case (which)
      0: {b100.start, b100.in_valid, b100.a, b100.b, b100.sum, b100.carry} = {st, v, a, b, s, c};
      1: {b1.start,   b1.in_valid,   b1.a,   b1.b,   b1.sum,   b1.carry}   = {st, v, a, b, s, c};
      3: {b3.start,   b3.in_valid,   b3.a,   b3.b,   b3.sum,   b3.carry}   = {st, v, a, b, s, c};
      default: {b4.start, b4.in_valid, b4.a, b4.b, b4.sum, b4.carry}     = {st, v, a, b, s, c};
    endcase
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    vecs++; if ({b100.busy, b100.done, b100.pass} !== 3'b000) begin errs++; $display("FAIL reset_flags: got %b want 000", {b100.busy, b100.done, b100.pass}); end
    vecs++; if (b100.err_count !== 8'h00) begin errs++; $display("FAIL reset_err: got %h want 00", b100.err_count); end
    vecs++; if (b100.first_err_idx !== 8'hFF) begin errs++; $display("FAIL reset_first: got %h want ff", b100.first_err_idx); end
    vecs++; if (b100.signature !== 16'hFFFF) begin errs++; $display("FAIL reset_sig: got %h want ffff", b100.signature); end
    // in_valid while IDLE must not disturb anything
    cyc(0, 0, 1, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    vecs++; if ({b100.busy, b100.signature} !== {1'b0, 16'hFFFF}) begin errs++; $display("FAIL idle_valid_ignored: got busy=%b sig=%h want 0 ffff", b100.busy, b100.signature); end
  endtask

  task automatic test_all_correct;
    bit a, b;
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      a = 1'($urandom_range(1)); b = 1'($urandom_range(1));
      cyc(0, 0, 1, a, b, a ^ b, a & b);
      if (i == 0) begin
        vecs++; if ({b100.busy, b100.signature} !== {1'b1, 16'hFFFF}) begin errs++; $display("FAIL start_busy: got busy=%b sig=%h want 1 ffff", b100.busy, b100.signature); end
      end
      if (i == 99) begin
        vecs++; if ({b100.busy, b100.done} !== 2'b10) begin errs++; $display("FAIL busy_after_99: got %b want 10", {b100.busy, b100.done}); end
      end
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    vecs++; if ({b100.busy, b100.done, b100.pass} !== 3'b011) begin errs++; $display("FAIL done_after_100: got %b want 011", {b100.busy, b100.done, b100.pass}); end
    vecs++; if ({b100.err_count, b100.first_err_idx} !== {8'h00, 8'hFF}) begin errs++; $display("FAIL clean_counts: got %h %h want 00 ff", b100.err_count, b100.first_err_idx); end
  endtask

  task automatic test_single_misr;
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    vecs++; if ({b1.done, b1.pass, b1.signature} !== {2'b11, 16'hEFDF}) begin errs++; $display("FAIL single_00: got done/pass=%b%b sig=%h want 11 efdf", b1.done, b1.pass, b1.signature); end
    // samples offered in DONE are ignored
    cyc(1, 0, 1, 1, 1, 0, 1);
    cyc(1, 0, 1, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    vecs++; if ({b1.done, b1.err_count, b1.signature} !== {1'b1, 8'h00, 16'hEFDF}) begin errs++; $display("FAIL done_hold: got done=%b err=%h sig=%h want 1 00 efdf", b1.done, b1.err_count, b1.signature); end
    // start together with in_valid: sample dropped, run reinitialised
    cyc(1, 1, 1, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    vecs++; if ({b1.busy, b1.done, b1.signature} !== {2'b10, 16'hFFFF}) begin errs++; $display("FAIL start_drops_sample: got busy/done=%b%b sig=%h want 10 ffff", b1.busy, b1.done, b1.signature); end
    cyc(1, 0, 1, 1, 1, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    vecs++; if ({b1.done, b1.pass, b1.signature} !== {2'b11, 16'hEFDD}) begin errs++; $display("FAIL single_11: got done/pass=%b%b sig=%h want 11 efdd", b1.done, b1.pass, b1.signature); end
  endtask

  task automatic test_inject;
    bit a, b, s;
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      a = 1'($urandom_range(1)); b = 1'($urandom_range(1));
      s = (i == 7 || i == 42) ? ~(a ^ b) : (a ^ b);
      cyc(0, 0, 1, a, b, s, a & b);
      if (i == 8) begin
        vecs++; if ({b100.err_count, b100.first_err_idx} !== {8'd1, 8'd7}) begin errs++; $display("FAIL first_err_latch: got %0d %0d want 1 7", b100.err_count, b100.first_err_idx); end
      end
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    vecs++; if ({b100.done, b100.pass} !== 2'b10) begin errs++; $display("FAIL inject_flags: got done/pass=%b want 10", {b100.done, b100.pass}); end
    vecs++; if ({b100.err_count, b100.first_err_idx} !== {8'd2, 8'd7}) begin errs++; $display("FAIL inject_counts: got %0d %0d want 2 7", b100.err_count, b100.first_err_idx); end
  endtask

  task automatic test_gaps_midstart;
    int k = 0;
    int c = 0;
    bit v, st;
    cyc(0, 1, 0, 0, 0, 0, 0);
    while (k < 100) begin
      v  = c[0];
      st = (c == 41);
      if (v && k == 99) begin
        vecs++; if (b100.done !== 1'b0) begin errs++; $display("FAIL gap_early_done: got %b want 0", b100.done); end
      end
      // only sample index 10 is wrong; a honoured mid-run start would erase it
      cyc(0, st, v, 1, 0, (v && k == 10) ? 1'b0 : 1'b1, 0);
      if (c == 42) begin
        vecs++; if (b100.busy !== 1'b1) begin errs++; $display("FAIL midstart_busy: got %b want 1", b100.busy); end
      end
      if (v) k++;
      c++;
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    vecs++; if ({b100.done, b100.pass} !== 2'b10) begin errs++; $display("FAIL gap_done: got done/pass=%b want 10", {b100.done, b100.pass}); end
    vecs++; if ({b100.err_count, b100.first_err_idx} !== {8'd1, 8'd10}) begin errs++; $display("FAIL midstart_ignored: got %0d %0d want 1 10", b100.err_count, b100.first_err_idx); end
  endtask

  task automatic test_reset_midrun;
    bit a, b;
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) cyc(0, 0, 1, 1, 1, (i == 5), 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    vecs++; if ({b100.busy, b100.err_count} !== {1'b1, 8'd1}) begin errs++; $display("FAIL pre_reset_state: got busy=%b err=%0d want 1 1", b100.busy, b100.err_count); end
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    vecs++; if ({b100.busy, b100.done, b100.pass, b100.err_count, b100.first_err_idx, b100.signature} !== {3'b000, 8'h00, 8'hFF, 16'hFFFF}) begin
      errs++; $display("FAIL midrun_reset: got %b%b%b %h %h %h want 000 00 ff ffff", b100.busy, b100.done, b100.pass, b100.err_count, b100.first_err_idx, b100.signature);
    end
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      a = 1'($urandom_range(1)); b = 1'($urandom_range(1));
      cyc(0, 0, 1, a, b, a ^ b, a & b);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    vecs++; if ({b100.done, b100.pass, b100.err_count, b100.first_err_idx} !== {2'b11, 8'h00, 8'hFF}) begin
      errs++; $display("FAIL rerun_after_reset: got %b%b %h %h want 11 00 ff", b100.done, b100.pass, b100.err_count, b100.first_err_idx);
    end
  endtask

  task automatic test_saturation;
    cyc(3, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(3, 0, 1, 0, 0, 1, 0);
    cyc(3, 0, 0, 0, 0, 0, 0);
    vecs++; if ({b3.done, b3.pass, b3.err_count, b3.first_err_idx} !== {2'b10, 2'd3, 2'd0}) begin
      errs++; $display("FAIL three_errors: got %b%b %0d %0d want 10 3 0", b3.done, b3.pass, b3.err_count, b3.first_err_idx);
    end
    cyc(4, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(4, 0, 1, 1, 0, 1, 1);
    cyc(4, 0, 0, 0, 0, 0, 0);
    vecs++; if ({b4.done, b4.pass, b4.err_count} !== {2'b10, 2'b11}) begin
      errs++; $display("FAIL err_saturate: got done/pass=%b%b err=%b want 10 11", b4.done, b4.pass, b4.err_count);
    end
  endtask

  initial begin
    test_reset;
    test_all_correct;
    test_single_misr;
    test_inject;
    test_gaps_midstart;
    test_reset_midrun;
    test_saturation;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ha_response_checker.md
# ha_response_checker

Synthesizable response-side companion for the half-adder test flow. It samples each stimulus/response pair (`a`, `b`, `sum`, `carry`) on a valid strobe and checks it against the golden half-adder function. It counts and locates mismatches and compacts all responses into a MISR signature, so that a fixed-length random run yields a single pass/fail plus signature. It sits at the output of the device under test, opposite the stimulus generator, and is usable on-chip (BIST) or in benches.

## Interface
- `NUM_VECTORS`, 100: number of accepted samples per run (≥1).
- `CNT_W`, 8: width of the vector index, error counter and first-error index; must hold `NUM_VECTORS-1`.
- `MISR_W`, 16: signature width (≥4).
- `MISR_POLY`, 16'h1021: feedback polynomial, MISR_W bits.
- `MISR_SEED`, 16'hFFFF: signature value loaded at reset and at each start.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run; honoured in IDLE and DONE only.
- `in_valid`  in  1  a/b/sum/carry are valid this cycle.
- `a`, `b`  in  1 each  stimulus applied to the DUT.
- `sum`, `carry`  in  1 each  DUT response.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  high in DONE when `err_count == 0`.
- `err_count`  out  CNT_W  mismatching samples, saturating at all-ones.
- `first_err_idx`  out  CNT_W  index of the first mismatching sample (0-based); all-ones if none.
- `signature`  out  MISR_W  current MISR state.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE when the sample with index `NUM_VECTORS-1` is accepted.
  - DONE → RUN on `start`.
  - No other transitions.
- On entry to RUN: clear vector index, `err_count` and `err_seen`. Set `first_err_idx` to all-ones and `signature` to MISR_SEED.
- A sample is accepted when `in_valid` is high in RUN. `in_valid` in IDLE or DONE is ignored, with no state change.
- Per accepted sample:
  - expected `sum = a ^ b`, expected `carry = a & b`.
  - Mismatch if either bit differs. On mismatch, `err_count` increments unless already all-ones.
  - On the first mismatch of a run, `first_err_idx` latches the current index.
  - Vector index increments.
- MISR update per accepted sample: `sig' = (sig << 1) ^ (sig[MISR_W-1] ? MISR_POLY : 0) ^ {0…, carry, sum}`. Received DUT bits are used, not expected bits.
- `start` in RUN is ignored; the run continues.
- `start` coinciding with `in_valid` in IDLE or DONE: the sample is dropped and the run initialises.
- `rst` mid-run: abandon the run. All outputs go to reset values on the next edge.
- Results (`err_count`, `first_err_idx`, `signature`, `pass`) hold stable in DONE until the next `start` or `rst`.

## Timing
- Reset values:
  - state IDLE; `busy`, `done`, `pass` = 0.
  - `err_count` = 0; `first_err_idx` = all-ones; `signature` = MISR_SEED.
- All outputs are registered; no combinational input-to-output path.
- `start` sampled at edge N → `busy` = 1 after edge N.
- A sample is accepted at edge N. Its effect on `err_count`, `first_err_idx` and `signature` is visible after edge N (latency 1).
- Last sample accepted at edge N → `busy` = 0, `done` = 1 and `pass` are valid after edge N.
- Throughput: one sample per cycle. Gaps in `in_valid` are allowed and do not advance the index.

## Structure
- Package `ha_check_pkg` holds:
  - state enum `ha_chk_state_t` {IDLE, RUN, DONE};
  - default MISR_POLY / MISR_SEED constants;
  - pure function `ha_expected(a,b)` returning {carry,sum}.
- One sub-module, `misr`, parameterised by width, polynomial and seed, with inputs `clk`, `rst`, `load`, `en` and `din[1:0]`.
- The top module holds the FSM, counters and the compare logic.

## Test plan
- All-correct 100-vector run with random a/b and an ideal DUT model → `done`=1 and `pass`=1 one cycle after the 100th accept; `err_count`=0; `first_err_idx`=8'hFF.
- NUM_VECTORS=1, single sample a=0, b=0, sum=0, carry=0 → `signature`=16'hEFDF, `pass`=1. Rerun with a=1, b=1, sum=0, carry=1 → `signature`=16'hEFDD.
- Inject wrong `sum` at samples 7 and 42 of 100 → `err_count`=2, `first_err_idx`=7, `pass`=0.
- Toggle `in_valid` 50% with `start` pulsed mid-RUN → exactly 100 accepts are needed, and the mid-run `start` has no effect.
- `rst` asserted after 30 accepts → next cycle IDLE, all outputs at reset values. A new `start` then completes a clean run.
- CNT_W=2, NUM_VECTORS=3, all three samples wrong → `err_count`=3. With NUM_VECTORS=3 and CNT_W=2, saturation does not trigger. Additionally run CNT_W=2 with forced count 3 plus one more error → count remains 2'b11.
